// File: rtl/booth_mul_arbiter.sv
// Round-robin front end that time-shares one sequential Booth multiplier core among NREQ requesters.
// Optional BOOTH_MUL_ARB_ZERO_SKIP_EN: zero operands bypass the core and respond immediately with 0.
module booth_mul_arbiter #(
    parameter  int NREQ       = 4,
    parameter  int W          = 32,
    parameter  int MUL_CYCLES = 32,
    localparam int ID_W       = $clog2(NREQ)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NREQ-1:0]     i_req_valid,
    input  logic [NREQ*W-1:0]   i_req_a,
    input  logic [NREQ*W-1:0]   i_req_b,
    output logic [NREQ-1:0]     o_req_ready,
    output logic                o_rsp_valid,
    output logic [ID_W-1:0]     o_rsp_id,
    output logic [2*W-1:0]      o_rsp_result,
    input  logic                i_rsp_ready,
    output logic                o_mul_clr,
    output logic                o_mul_load,
    output logic [W-1:0]        o_mul_a,
    output logic [W-1:0]        o_mul_b,
    input  logic [2*W-1:0]      i_mul_p,
    output logic                o_busy
);

    localparam int CNT_W = $clog2(MUL_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LOAD,
        S_RUN,
        S_CAPT,
        S_RSP
    } state_t;

    state_t            state, state_n;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   owner;
    logic [W-1:0]      a_q, b_q;
    logic [CNT_W-1:0]  cnt;
    logic [2*W-1:0]    rsp_result;
    logic [ID_W-1:0]   rsp_id;

    logic              grant_any;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   cand;
    logic [W-1:0]      grant_a, grant_b;
    logic              zero_op;
    logic              take;
    logic [NREQ-1:0]   req_ready;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = ID_W'((int'(rr_ptr) + i) % NREQ);
            if (!grant_any && i_req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign grant_a = i_req_a[grant_idx*W +: W];
    assign grant_b = i_req_b[grant_idx*W +: W];

`ifdef BOOTH_MUL_ARB_ZERO_SKIP_EN
    assign zero_op = (grant_a == '0) || (grant_b == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        req_ready = '0;
        take      = 1'b0;
        case (state)
            S_IDLE: begin
                if (grant_any) begin
                    take                 = 1'b1;
                    req_ready[grant_idx] = 1'b1;
                    state_n              = zero_op ? S_RSP : S_CLR;
                end
            end
            S_CLR:  state_n = S_LOAD;
            S_LOAD: state_n = S_RUN;
            S_RUN:  if (cnt == CNT_W'(1)) state_n = S_CAPT;
            S_CAPT: state_n = S_RSP;
            S_RSP:  if (i_rsp_ready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cnt        <= '0;
            rsp_result <= '0;
            rsp_id     <= '0;
        end else begin
            state <= state_n;
            if (take) begin
                a_q    <= grant_a;
                b_q    <= grant_b;
                owner  <= grant_idx;
                rr_ptr <= (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                if (zero_op) begin
                    rsp_result <= '0;
                    rsp_id     <= grant_idx;
                end
            end
            // Counter spans exactly MUL_CYCLES RUN cycles after the load pulse.
            if (state == S_LOAD)
                cnt <= CNT_W'(MUL_CYCLES);
            else if (state == S_RUN)
                cnt <= cnt - 1'b1;
            if (state == S_CAPT) begin
                rsp_result <= i_mul_p;
                rsp_id     <= owner;
            end
        end
    end

    // Reset gating keeps the accept strobe low while reset is held with requests pending.
    assign o_req_ready  = i_rst ? '0 : req_ready;
    assign o_rsp_valid  = (state == S_RSP);
    assign o_rsp_id     = rsp_id;
    assign o_rsp_result = rsp_result;
    assign o_mul_clr    = (state == S_CLR);
    assign o_mul_load   = (state == S_LOAD);
    assign o_mul_a      = (state == S_IDLE) ? '0 : a_q;
    assign o_mul_b      = (state == S_IDLE) ? '0 : b_q;
    assign o_busy       = (state != S_IDLE);

endmodule
